// File: rtl/imem_loader.sv
// Byte-stream loader that writes framed 32-bit words into instruction memory.
// Define IMEM_LOADER_CKSUM_EN to require a trailing XOR checksum byte per frame.
`timescale 1ns/1ps
module imem_loader #(
  parameter int          ADDR_W    = 8,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              core_hold,
  output logic              done,
  output logic              error
);

`ifdef IMEM_LOADER_CKSUM_EN
  typedef enum logic [2:0] {
    IDLE, COUNT, DATA, WRITE, CKSUM, DONE, ERR
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, COUNT, DATA, WRITE, DONE
  } state_t;
`endif

  state_t              state_q;
  logic [7:0]          cnt_q;
  logic [7:0]          widx_q;
  logic [1:0]          bidx_q;
  logic [23:0]         shift_q;
  logic                rdy_q;
  logic                wen_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic [31:0]         wdata_q;
  logic                hold_q;
  logic                done_q;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0]          xor_q;
  logic                err_q;
`endif

  logic xfer, is_sync, last;
  assign xfer    = s_valid & rdy_q;
  assign is_sync = (s_data == SYNC_BYTE);
  assign last    = (widx_q == cnt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      widx_q  <= '0;
      bidx_q  <= '0;
      shift_q <= '0;
      rdy_q   <= 1'b0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
      xor_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      wen_q <= 1'b0;
      rdy_q <= 1'b1;
      unique case (state_q)
`ifdef IMEM_LOADER_CKSUM_EN
        IDLE, DONE, ERR: begin
`else
        IDLE, DONE: begin
`endif
          if (xfer && is_sync) begin
            state_q <= COUNT;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
            err_q   <= 1'b0;
`endif
          end
        end
        COUNT: begin
          if (xfer) begin
            cnt_q   <= s_data;
            widx_q  <= '0;
            bidx_q  <= '0;
            state_q <= DATA;
`ifdef IMEM_LOADER_CKSUM_EN
            xor_q   <= s_data;
`endif
          end
        end
        DATA: begin
          if (xfer) begin
            shift_q <= {shift_q[15:0], s_data};
            bidx_q  <= bidx_q + 2'd1;
`ifdef IMEM_LOADER_CKSUM_EN
            xor_q   <= xor_q ^ s_data;
`endif
            if (bidx_q == 2'd3) begin
              state_q <= WRITE;
              wen_q   <= 1'b1;
              rdy_q   <= 1'b0;
              waddr_q <= ADDR_W'(widx_q);
              wdata_q <= {shift_q, s_data};
`ifndef IMEM_LOADER_CKSUM_EN
              // No checksum: release the core on the final data byte.
              if (last) begin
                done_q <= 1'b1;
                hold_q <= 1'b0;
              end
`endif
            end
          end
        end
        WRITE: begin
          if (last) begin
`ifdef IMEM_LOADER_CKSUM_EN
            state_q <= CKSUM;
`else
            state_q <= DONE;
`endif
          end else begin
            widx_q  <= widx_q + 8'd1;
            state_q <= DATA;
          end
        end
`ifdef IMEM_LOADER_CKSUM_EN
        CKSUM: begin
          if (xfer) begin
            if (s_data == xor_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end else begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready   = rdy_q;
  assign wr_en     = wen_q;
  assign wr_addr   = waddr_q;
  assign wr_data   = wdata_q;
  assign core_hold = hold_q;
  assign done      = done_q;
`ifdef IMEM_LOADER_CKSUM_EN
  assign error     = err_q;
`else
  assign error     = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader.
// Honors IMEM_LOADER_CKSUM_EN to match the DUT build.
`timescale 1ns/1ps
module tb_imem_loader;

`ifdef IMEM_LOADER_CKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        core_hold;
  logic        done;
  logic        error;

  imem_loader #(.ADDR_W(8), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .core_hold(core_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   rdy_low = 0;
  wr_t  got[$];
  wr_t  exp_w[$];
  logic [7:0] tx[$];
  bit   exp_ok;

  always @(negedge clk) begin
    if (rst_n && wr_en) got.push_back({wr_addr, wr_data});
    if (rst_n && !s_ready) rdy_low++;
  end

  // Reference: frame = A5, CNT, (CNT+1) words MSB first, optional XOR byte.
  task automatic build(input int cnt, input bit bad, input bit syncdat);
    logic [7:0]  ck;
    logic [31:0] w;
    tx.delete();
    exp_w.delete();
    tx.push_back(8'hA5);
    tx.push_back(8'(cnt));
    ck = 8'(cnt);
    for (int i = 0; i <= cnt; i++) begin
      w = syncdat ? 32'hA5A5_A5A5 : $urandom;
      for (int k = 3; k >= 0; k--) begin
        tx.push_back(w[k*8 +: 8]);
        ck ^= w[k*8 +: 8];
      end
      exp_w.push_back({8'(i % 256), w});
    end
    if (CK) tx.push_back(bad ? (ck ^ 8'h01) : ck);
    exp_ok = !(CK && bad);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = b;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      n++;
      if (n > 200) begin
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: s_ready=%b required 1", s_ready);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_tx(input int gap_pct);
    foreach (tx[i]) begin
      if ($urandom_range(99) < gap_pct) begin
        s_valid = 1'b0;
        repeat ($urandom_range(3, 1)) @(posedge clk);
        #1;
      end
      send_byte(tx[i]);
    end
    s_valid = 1'b0;
  endtask

  task automatic check_frame(input string nm);
    repeat (4) @(posedge clk);
    #1;
    n_tests++;
    if (got.size() !== exp_w.size()) begin
      n_fail++;
      $display("FAIL %s nwrites: got %0d required %0d",
               nm, got.size(), exp_w.size());
    end
    for (int i = 0; i < exp_w.size() && i < got.size(); i++) begin
      n_tests++;
      if (got[i] !== exp_w[i]) begin
        n_fail++;
        $display("FAIL %s write%0d: got %h/%h required %h/%h", nm, i,
                 got[i].a, got[i].d, exp_w[i].a, exp_w[i].d);
      end
    end
    n_tests++;
    if ({done, error, core_hold} !== {exp_ok, !exp_ok, !exp_ok}) begin
      n_fail++;
      $display("FAIL %s status: done/err/hold=%b%b%b required %b%b%b",
               nm, done, error, core_hold, exp_ok, !exp_ok, !exp_ok);
    end
  endtask

  task automatic set_fixed(input logic [7:0] ck);
    tx.delete();
    exp_w.delete();
    tx = '{8'hA5, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    if (CK) tx.push_back(ck);
    exp_w.push_back({8'h00, 32'hDEAD_BEEF});
    exp_ok = !(CK && ck != 8'h22);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({s_ready, wr_en, core_hold, done, error} !== 5'b00100) begin
      n_fail++;
      $display("FAIL reset_ctl: rdy/wen/hold/done/err=%b%b%b%b%b required 00100",
               s_ready, wr_en, core_hold, done, error);
    end
    n_tests++;
    if ({wr_addr, wr_data} !== 40'h0) begin
      n_fail++;
      $display("FAIL reset_wr: got %h/%h required 0/0", wr_addr, wr_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if ({s_ready, core_hold, wr_en, done} !== 4'b1100) begin
      n_fail++;
      $display("FAIL release: rdy/hold/wen/done=%b%b%b%b required 1100",
               s_ready, core_hold, wr_en, done);
    end
  endtask

  task automatic test_single();
    got.delete();
    set_fixed(8'h22);
    for (int i = 0; i < 6; i++) send_byte(tx[i]);
    n_tests++;
    if ({wr_en, s_ready, wr_addr, wr_data} !== {2'b10, 8'h00, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL single_lat: wen/rdy=%b%b %h/%h required 10 00/deadbeef",
               wr_en, s_ready, wr_addr, wr_data);
    end
    if (CK) send_byte(tx[6]);
    s_valid = 1'b0;
    n_tests++;
    if ({done, core_hold} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_done_lat: done/hold=%b%b required 10",
               done, core_hold);
    end
    check_frame("single");
  endtask

  task automatic test_junk();
    got.delete();
    tx = '{8'h00, 8'hFF, 8'h13};
    send_tx(0);
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (got.size() !== 0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL junk: writes=%0d done=%b required 0 1", got.size(), done);
    end
    set_fixed(8'h22);
    send_tx(0);
    check_frame("junk_frame");
  endtask

  task automatic test_back_to_back();
    got.delete();
    build(1, 1'b0, 1'b0);
    rdy_low = 0;
    send_tx(0);
    check_frame("b2b");
    n_tests++;
    if (rdy_low !== 2) begin
      n_fail++;
      $display("FAIL b2b_ready_low: got %0d cycles required 2", rdy_low);
    end
  endtask

  task automatic test_cksum_err();
    got.delete();
    set_fixed(8'h23);
    send_tx(0);
    check_frame("cksum_bad");
    got.delete();
    build(2, 1'b0, 1'b0);
    send_tx(20);
    check_frame("cksum_recover");
  endtask

  task automatic test_mid_reset();
    got.delete();
    send_byte(8'hA5);
    s_valid = 1'b0;
    n_tests++;
    if ({done, error, core_hold} !== 3'b001) begin
      n_fail++;
      $display("FAIL sync_clear: done/err/hold=%b%b%b required 001",
               done, error, core_hold);
    end
    tx = '{8'h00, 8'hDE, 8'hAD};
    send_tx(0);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({s_ready, wr_en, core_hold, done, error, wr_addr, wr_data}
        !== {5'b00100, 40'h0}) begin
      n_fail++;
      $display("FAIL midreset: rdy/wen/hold/done/err=%b%b%b%b%b %h/%h required 00100 0/0",
               s_ready, wr_en, core_hold, done, error, wr_addr, wr_data);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (got.size() !== 0) begin
      n_fail++;
      $display("FAIL midreset_nowrite: writes=%0d required 0", got.size());
    end
    build(0, 1'b0, 1'b0);
    send_tx(0);
    check_frame("after_reset");
  endtask

  task automatic test_random();
    for (int f = 0; f < 16; f++) begin
      got.delete();
      build($urandom_range(7), $urandom_range(3) == 0, $urandom_range(5) == 0);
      send_tx(30);
      check_frame($sformatf("rand%0d", f));
    end
    got.delete();
    build(255, 1'b0, 1'b0);
    send_tx(5);
    check_frame("full_depth");
  endtask

  initial begin
    test_reset();
    test_single();
    test_junk();
    test_back_to_back();
    if (CK) test_cksum_err();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
